// File: rtl/mem_debug_dumper_pkg.sv
// Shared debug-unit definitions for the data-memory dumper.
// Contents:
//   - FSM state encodings (3-bit), exposed as plain constants and as an enum
//   - BYTES_PER_WORD / LAST_BYTE_IDX for the word serialiser
//   - DEBUG_MEM_SIGNALS: forced read-only memory control bits (read=1, write=0)
//     that the MEM stage applies while select_debug is high
//   - word_byte(): pick byte idx of a 32-bit word, LSB byte first
package mem_debug_dumper_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_WAIT_RD = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;
    localparam logic [2:0] ST_FINISH  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ADDR    = ST_ADDR,
        S_WAIT_RD = ST_WAIT_RD,
        S_SEND    = ST_SEND,
        S_WAIT_TX = ST_WAIT_TX,
        S_NEXT    = ST_NEXT,
        S_FINISH  = ST_FINISH
    } state_e;

    localparam int         BYTES_PER_WORD    = 4;
    localparam logic [1:0] LAST_BYTE_IDX     = 2'(BYTES_PER_WORD - 1);
    localparam logic [5:0] DEBUG_MEM_SIGNALS = 6'b110100;

    // Byte idx of a word; byte 0 is bits [7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_debug_dumper_word_serializer.sv
// Word serialiser for the memory dumper: holds the captured memory word and
// presents it one byte at a time, LSB byte first, on a registered tx_data.
// Ports:
//   clock_i, reset_i : clock, synchronous active-high reset
//   load_i           : capture data_i, select byte 0
//   data_i           : memory read data
//   advance_i        : step to the next byte of the captured word
//   byte_idx_o       : index of the byte currently on tx_data_o
//   tx_data_o        : byte presented to the UART transmitter
module mem_debug_dumper_word_serializer
    import mem_debug_dumper_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [NB_DATA-1:0] data_i,
    input  logic               advance_i,
    output logic [1:0]         byte_idx_o,
    output logic [7:0]         tx_data_o
);

    logic [NB_DATA-1:0] capture;

    // Capture register, byte index and registered byte mux.
    // tx_data_o is loaded together with the index so it is already stable
    // in the cycle tx_start_o is raised and stays put until the next advance.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            capture    <= '0;
            byte_idx_o <= 2'd0;
            tx_data_o  <= 8'd0;
        end else if (load_i) begin
            capture    <= data_i;
            byte_idx_o <= 2'd0;
            tx_data_o  <= word_byte(data_i, 2'd0);
        end else if (advance_i) begin
            byte_idx_o <= byte_idx_o + 2'd1;
            tx_data_o  <= word_byte(capture, byte_idx_o + 2'd1);
        end else begin
            capture    <= capture;
            byte_idx_o <= byte_idx_o;
            tx_data_o  <= tx_data_o;
        end
    end

endmodule

// File: rtl/mem_debug_dumper.sv
// Debug-side data-memory dumper. After the pipeline halts, a start pulse makes
// it walk data memory from address 0 to N_WORDS-1 through the MEM stage debug
// port and stream every word as 4 bytes (LSB first) into the UART TX.
// Ports:
//   clock_i, reset_i  : clock, synchronous active-high reset
//   start_i           : begin a dump (IDLE only)
//   abort_i           : stop the dump after the byte in flight
//   data_read_i       : read data from the MEM stage, READ_LAT cycles after address
//   tx_done_i         : UART TX finished the current byte
//   addr_mem_debug_o  : debug word address into the MEM stage
//   select_debug_o    : MEM stage uses debug address and read-only controls
//   mem_en_o          : memory enable request
//   tx_data_o         : byte to send
//   tx_start_o        : one-cycle pulse launching tx_data_o
//   busy_o            : dump in progress
//   done_o            : one-cycle pulse when the dump completes or aborts
module mem_debug_dumper
    import mem_debug_dumper_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 7,
    parameter int N_WORDS  = 128,
    parameter int READ_LAT = 1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [NB_DATA-1:0] data_read_i,
    input  logic               tx_done_i,
    output logic [NB_ADDR-1:0] addr_mem_debug_o,
    output logic               select_debug_o,
    output logic               mem_en_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    output logic               busy_o,
    output logic               done_o
);

    // One extra bit so that N_WORDS == 2**NB_ADDR is reachable without wrapping.
    localparam int NB_CNT = NB_ADDR + 1;

    state_e            state;
    logic [NB_CNT-1:0] word_cnt;
    logic [NB_CNT-1:0] word_cnt_inc;
    logic [1:0]        wait_cnt;
    logic              abort_flag;
    logic              abort_any;
    logic              ser_load;
    logic              ser_advance;
    logic [1:0]        byte_idx;

    assign word_cnt_inc = word_cnt + NB_CNT'(1);

    // Serialiser strobes: capture on the last read-wait cycle, step to the
    // next byte when the UART acknowledges a non-final byte and no abort.
    always_comb begin
        abort_any   = abort_flag | abort_i;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
        if ((state == S_WAIT_RD) && (wait_cnt == 2'd1)) begin
            ser_load = 1'b1;
        end else begin
            ser_load = 1'b0;
        end
        if ((state == S_WAIT_TX) && tx_done_i && !abort_any && (byte_idx != LAST_BYTE_IDX)) begin
            ser_advance = 1'b1;
        end else begin
            ser_advance = 1'b0;
        end
    end

    // Dump FSM with registered outputs; outputs are set on entry to a state
    // so they hold the documented values for the whole time in that state.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state            <= S_IDLE;
            word_cnt         <= '0;
            wait_cnt         <= 2'd0;
            abort_flag       <= 1'b0;
            addr_mem_debug_o <= '0;
            select_debug_o   <= 1'b0;
            mem_en_o         <= 1'b0;
            tx_start_o       <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    abort_flag <= 1'b0;
                    done_o     <= 1'b0;
                    tx_start_o <= 1'b0;
                    if (start_i) begin
                        state            <= S_ADDR;
                        word_cnt         <= '0;
                        addr_mem_debug_o <= '0;
                        select_debug_o   <= 1'b1;
                        mem_en_o         <= 1'b1;
                        busy_o           <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    abort_flag <= abort_any;
                    wait_cnt   <= 2'(READ_LAT);
                    state      <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    abort_flag <= abort_any;
                    wait_cnt   <= wait_cnt - 2'd1;
                    // Data is sampled by the serialiser on this same edge.
                    if (wait_cnt == 2'd1) begin
                        state      <= S_SEND;
                        tx_start_o <= 1'b1;
                    end else begin
                        state <= S_WAIT_RD;
                    end
                end
                S_SEND: begin
                    abort_flag <= abort_any;
                    tx_start_o <= 1'b0;
                    state      <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    abort_flag <= abort_any;
                    if (tx_done_i) begin
                        if (abort_any) begin
                            state          <= S_FINISH;
                            done_o         <= 1'b1;
                            busy_o         <= 1'b0;
                            select_debug_o <= 1'b0;
                            mem_en_o       <= 1'b0;
                        end else if (byte_idx != LAST_BYTE_IDX) begin
                            state      <= S_SEND;
                            tx_start_o <= 1'b1;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else begin
                        state <= S_WAIT_TX;
                    end
                end
                S_NEXT: begin
                    abort_flag <= abort_any;
                    word_cnt   <= word_cnt_inc;
                    if (word_cnt_inc == NB_CNT'(N_WORDS)) begin
                        state          <= S_FINISH;
                        done_o         <= 1'b1;
                        busy_o         <= 1'b0;
                        select_debug_o <= 1'b0;
                        mem_en_o       <= 1'b0;
                    end else begin
                        state            <= S_ADDR;
                        addr_mem_debug_o <= word_cnt_inc[NB_ADDR-1:0];
                    end
                end
                S_FINISH: begin
                    abort_flag <= 1'b0;
                    done_o     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state          <= S_IDLE;
                    abort_flag     <= 1'b0;
                    select_debug_o <= 1'b0;
                    mem_en_o       <= 1'b0;
                    tx_start_o     <= 1'b0;
                    busy_o         <= 1'b0;
                    done_o         <= 1'b0;
                end
            endcase
        end
    end

    mem_debug_dumper_word_serializer #(
        .NB_DATA (NB_DATA)
    ) u_word_serializer (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (ser_load),
        .data_i     (data_read_i),
        .advance_i  (ser_advance),
        .byte_idx_o (byte_idx),
        .tx_data_o  (tx_data_o)
    );

endmodule

// File: doc/mem_debug_dumper.md
Name: mem_debug_dumper

Overview:
- Debug-side neighbour of the MEM stage.
- Once the pipeline is halted, it walks data memory word by word.
  - Drives the MEM stage's debug address and debug select.
  - Captures the read data coming back from the MEM stage.
  - Serialises each word as 4 bytes into the UART transmitter handshake.
- Sits between the MEM stage top and the debug UART TX in the debug unit.

Parameters:
- NB_DATA, 32: memory word width; must be 32 (4 bytes per word).
- NB_ADDR, 7: width of the debug memory address.
- N_WORDS, 128: number of words dumped, addresses 0..N_WORDS-1; 1 <= N_WORDS <= 2**NB_ADDR.
- READ_LAT, 1: cycles from address/enable applied to read data valid at data_read_i; range 1..3.

Ports:
- clock_i, in, 1: system clock, all state on rising edge.
- reset_i, in, 1: synchronous, active-high reset.
- start_i, in, 1: one-cycle request to begin a dump; honoured only in IDLE.
- abort_i, in, 1: terminate an in-progress dump at the next byte boundary.
- data_read_i, in, NB_DATA: read data from the MEM stage.
- tx_done_i, in, 1: one-cycle pulse from the UART TX, meaning the byte has been sent.
- addr_mem_debug_o, out, NB_ADDR: debug address into the MEM stage.
- select_debug_o, out, 1: high selects the debug address and forced read-only memory signals in the MEM stage.
- mem_en_o, out, 1: memory enable request; ORed with en_pipeline at top level.
- tx_data_o, out, 8: byte to transmit.
- tx_start_o, out, 1: one-cycle pulse starting transmission of tx_data_o.
- busy_o, out, 1: high from acceptance of start_i until return to IDLE.
- done_o, out, 1: one-cycle pulse when a dump completes or aborts.

Behaviour:
- Reset values, applied synchronously while reset_i=1 regardless of state:
  - All outputs 0.
  - State IDLE; word counter 0; byte index 0; capture register 0.
- States: IDLE, ADDR, WAIT_RD, SEND, WAIT_TX, NEXT, FINISH.
- IDLE:
  - busy_o=0, select_debug_o=0.
  - start_i=1 -> ADDR; word counter cleared; busy_o=1 from the next cycle.
- ADDR:
  - addr_mem_debug_o = word counter (low NB_ADDR bits).
  - select_debug_o=1, mem_en_o=1.
  - Wait counter loaded with READ_LAT -> WAIT_RD.
- WAIT_RD:
  - Holds address, select and enable; decrements the wait counter.
  - At 0: capture data_read_i; byte index = 0 -> SEND.
- SEND:
  - tx_data_o = capture[8*idx+7 : 8*idx], LSB byte first.
  - tx_start_o=1 for exactly this cycle -> WAIT_TX.
- WAIT_TX:
  - tx_data_o held stable.
  - On tx_done_i=1:
    - abort_i seen (sticky flag) -> FINISH.
    - else idx<3 -> idx+1, SEND.
    - else -> NEXT.
  - tx_done_i is ignored in every state other than WAIT_TX.
- NEXT:
  - Word counter +1. The counter is NB_ADDR+1 bits wide, so there is no wrap at 2**NB_ADDR.
  - counter+1 == N_WORDS -> FINISH; else -> ADDR.
- FINISH:
  - done_o=1 for one cycle; select_debug_o=0, mem_en_o=0, busy_o=0 -> IDLE.
- select_debug_o and mem_en_o are 1 in ADDR, WAIT_RD, SEND, WAIT_TX and NEXT.
  - Select stays high throughout so the MEM stage's memory signals stay read-only; no write can ever occur during a dump.
- Abort handling:
  - abort_i in any busy state sets a sticky abort flag; the flag is cleared in IDLE.
  - The byte currently in flight always completes.
  - Abort arriving in ADDR/WAIT_RD/NEXT takes effect at the next WAIT_TX exit; abort in IDLE has no effect.
- start_i while busy is ignored and not queued.
- start_i and abort_i together in IDLE: start wins; the abort in that same cycle is ignored.
- Reset mid-dump: immediate return to IDLE and select dropped. No done_o pulse and no partial byte is issued.
- Latency, per word: 1 (ADDR) + READ_LAT + 4×(1 + TX time) + 1 (NEXT).

Decomposition:
- Shared debug package:
  - State encoding constants (3-bit localparams).
  - BYTES_PER_WORD = 4.
  - Forced debug memory-signal constant 6'b110100 (read=1, write=0), shared with the MEM stage.
- One natural sub-module, word_serializer: capture register plus byte index and byte mux, driving tx_data_o.
- The FSM, counters and address drive stay in mem_debug_dumper.

Test Plan:
- Basic dump:
  - Stimulus: N_WORDS=2; memory word0=32'h11223344, word1=32'hA5A5_0F0F; start_i pulse; UART model gives tx_done_i 5 cycles after each tx_start_o.
  - Response: byte stream 44,33,22,11,0F,0F,A5,A5; addr 0 then 1; one done_o pulse; select_debug_o low afterwards.
- Read latency:
  - Stimulus: READ_LAT=3.
  - Response: capture occurs exactly 3 cycles after ADDR; data matches word0.
  - Repeat with READ_LAT=1.
- Abort:
  - Stimulus: abort_i during the second byte of word0.
  - Response: that byte completes; no further tx_start_o; done_o pulses; busy_o=0; next start_i dumps again from address 0.
- Full range:
  - Stimulus: N_WORDS=128, NB_ADDR=7.
  - Response: last address 7'h7F; 512 bytes total; no wrap to 0; done_o after the 512th tx_done_i.
- Spurious inputs:
  - Stimulus: start_i during WAIT_TX; tx_done_i pulses in IDLE and in WAIT_RD.
  - Response: no restart and no extra tx_start_o; the byte sequence is unchanged.
- Reset mid-dump:
  - Stimulus: reset_i=1 in WAIT_RD of word 5.
  - Response: next cycle all outputs 0, no done_o; a subsequent start_i begins at address 0.
